// File: rtl/keypad_scan_pkg.sv
// Shared constants, state encodings and the key-code mapping for the 3x4 keypad scanner.
package keypad_scan_pkg;

  localparam int NUM_ROWS  = 4;
  localparam int NUM_COLS  = 3;
  localparam int SNAP_BITS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_ZERO = 4'd0;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_PRESSED,
    ST_REL
  } scan_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } sweep_cls_e;

  // Digits 1..9 occupy the top three rows; the bottom row carries *, 0, #.
  function automatic logic [3:0] key_code(input int unsigned row, input int unsigned col);
    if (row < NUM_ROWS - 1) begin
      return 4'(row * NUM_COLS + col + 1);
    end
    case (col)
      0:       return KEY_STAR;
      1:       return KEY_ZERO;
      default: return KEY_HASH;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side and consumer-side signals of the keypad scanner.
interface keypad_scan_if;
  import keypad_scan_pkg::*;

  logic [NUM_ROWS-1:0] key_row;
  logic [NUM_COLS-1:0] key_col;
  logic [3:0]          key_data;
  logic                key_valid;
  logic                key_held;

  modport master (
    input  key_row,
    output key_col,
    output key_data,
    output key_valid,
    output key_held
  );

  modport slave (
    output key_row,
    input  key_col,
    input  key_data,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_tick_gen.sv
// Column dwell timer and column rotator; tick marks the last cycle of each dwell.
module scan_tick_gen
  import keypad_scan_pkg::*;
#(
  parameter int CLK_DIV = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [1:0] col_idx
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0]      COL_LAST = 2'(NUM_COLS - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       col_reg;

  assign tick    = (cnt_reg == CNT_LAST);
  assign col_idx = col_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      col_reg <= '0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        col_reg <= (col_reg == COL_LAST) ? 2'd0 : col_reg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// Keypad matrix scanner: synchronizes rows, builds a 12-bit sweep snapshot and
// debounces single-key presses and releases at sweep granularity.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int CLK_DIV        = 25000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp
);

  localparam int               DB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0]  DB_DONE = DB_W'(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);

  logic                  tick;
  logic [1:0]            col_idx;
  logic [NUM_COLS-1:0]   key_col_w;
  logic [NUM_ROWS-1:0]   row_meta_reg, row_sync_reg;
  logic [SNAP_BITS-1:0]  snap_reg, snap_next;
  logic                  sweep_end;
  logic [1:0]            hits;
  logic [3:0]            hit_code;
  sweep_cls_e            cls;

  scan_state_e           state_reg, state_next;
  logic [DB_W-1:0]       cnt_reg, cnt_next, cnt_inc;
  logic [3:0]            cand_reg, cand_next;
  logic [3:0]            data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  held_reg, held_next;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .col_idx (col_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
      assign key_col_w[gi] = (col_idx != 2'(gi));
    end
  endgenerate

  assign kp.key_col   = key_col_w;
  assign kp.key_data  = data_reg;
  assign kp.key_valid = valid_reg;
  assign kp.key_held  = held_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
      snap_reg     <= '0;
    end else begin
      row_meta_reg <= kp.key_row;
      row_sync_reg <= row_meta_reg;
      snap_reg     <= snap_next;
    end
  end

  // Classification looks at snap_next so the column stored on the closing tick is included.
  always_comb begin
    snap_next = snap_reg;
    if (tick) begin
      snap_next[col_idx*NUM_ROWS +: NUM_ROWS] = ~row_sync_reg;
    end
  end

  assign sweep_end = tick && (col_idx == 2'(NUM_COLS - 1));

  always_comb begin
    hits     = 2'd0;
    hit_code = 4'd0;
    for (int i = 0; i < SNAP_BITS; i++) begin
      if (snap_next[i]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_code = key_code(i % NUM_ROWS, i / NUM_ROWS);
      end
    end
    cls = (hits == 2'd0) ? CLS_NONE : ((hits == 2'd1) ? CLS_SINGLE : CLS_MULTI);
  end

  assign cnt_inc = (cnt_reg == DB_DONE) ? cnt_reg : cnt_reg + DB_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cand_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      held_reg  <= held_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    held_next  = held_reg;
    if (sweep_end) begin
      case (state_reg)
        ST_IDLE: begin
          if (cls == CLS_SINGLE) begin
            cand_next  = hit_code;
            cnt_next   = DB_ONE;
            state_next = ST_CAND;
          end
        end
        ST_CAND: begin
          if (cls == CLS_SINGLE && hit_code == cand_reg) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_DONE) begin
              data_next  = cand_reg;
              valid_next = 1'b1;
              held_next  = 1'b1;
              state_next = ST_PRESSED;
            end
          end else if (cls == CLS_SINGLE) begin
            cand_next = hit_code;
            cnt_next  = DB_ONE;
          end else begin
            cnt_next   = '0;
            state_next = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (!(cls == CLS_SINGLE && hit_code == data_reg)) begin
            cnt_next   = '0;
            state_next = ST_REL;
          end
        end
        ST_REL: begin
          // Any activity during release restarts the empty-sweep count; no rollover.
          if (cls == CLS_NONE) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_DONE) begin
              cnt_next   = '0;
              held_next  = 1'b0;
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized keypad bench: a sweep-level reference model feeds an expected-pulse
// queue that an independent monitor drains against key_valid/key_data.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;
  localparam int SWEEP   = CLK_DIV * NUM_COLS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_if kp_if();

  keypad_scan #(
    .CLK_DIV        (CLK_DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp_if)
  );

  // Pressed keys indexed by keypad position row*3+col.
  logic [11:0] pressed = '0;

  always_comb begin
    kp_if.key_row = 4'hF;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (!kp_if.key_col[c] && pressed[r*3+c]) kp_if.key_row[r] = 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int code;
    int sweep;
  } exp_t;
  exp_t exp_q[$];

  // Printed labels of the keypad, read left-to-right, top-to-bottom.
  int key_label[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  int m_data, m_held, m_down, m_streak_code, m_streak_len, m_empty_run;

  task automatic model_reset();
    m_data = 0; m_held = 0; m_down = 0;
    m_streak_code = 0; m_streak_len = 0; m_empty_run = 0;
    exp_q.delete();
  endtask

  task automatic model_sweep(input logic [11:0] set, input int sweep_no);
    int n;
    int k;
    n = $countones(set);
    k = -1;
    for (int i = 0; i < 12; i++) if (set[i]) k = key_label[i];
    if (!m_held) begin
      if (n == 1) begin
        if (m_streak_len > 0 && k == m_streak_code) m_streak_len++;
        else begin
          m_streak_code = k;
          m_streak_len  = 1;
        end
        if (m_streak_len == DB) begin
          m_data = k; m_held = 1; m_down = 1; m_streak_len = 0;
          exp_q.push_back('{k, sweep_no});
        end
      end else begin
        m_streak_len = 0;
      end
    end else if (m_down) begin
      if (!(n == 1 && k == m_data)) begin
        m_down = 0;
        m_empty_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_empty_run++;
        if (m_empty_run == DB) m_held = 0;
      end else begin
        m_empty_run = 0;
      end
    end
  endtask

  function automatic logic [11:0] km(input int pos);
    logic [11:0] m;
    m = '0;
    m[pos] = 1'b1;
    return m;
  endfunction

  // Called on a negedge aligned to a sweep boundary; holds set for n whole sweeps.
  task automatic run(input logic [11:0] set, input int n);
    for (int s = 0; s < n; s++) begin
      pressed = set;
      model_sweep(set, cyc / SWEEP + 1);
      repeat (SWEEP) @(negedge clk);
      $display("sweep %0d keys=%03h held=%0d data=%0d", cyc / SWEEP, set, kp_if.key_held, kp_if.key_data);
      check("key_held", kp_if.key_held, m_held);
      check("key_data", kp_if.key_data, m_data);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_key_col", kp_if.key_col, 3'b110);
    check("rst_key_data", kp_if.key_data, 0);
    check("rst_key_valid", kp_if.key_valid, 0);
    check("rst_key_held", kp_if.key_held, 0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    int ci;
    exp_t e;
    ci = (cyc / CLK_DIV) % NUM_COLS;
    check("key_col", kp_if.key_col, 3'b111 ^ (3'b001 << ci));
    if (rst_n) begin
      if (kp_if.key_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL valid_unexpected: got pulse code %0d at cyc %0d, expected no pulse", kp_if.key_data, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("pulse code=%0d cyc=%0d (expected code %0d at cyc %0d)", kp_if.key_data, cyc, e.code, e.sweep * SWEEP);
          check("valid_code", kp_if.key_data, e.code);
          check("valid_time", cyc, e.sweep * SWEEP);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].sweep * SWEEP) begin
        e = exp_q.pop_front();
        checks++;
        fails++;
        $display("FAIL valid_missing: got no pulse by cyc %0d, expected code %0d at cyc %0d", cyc, e.code, e.sweep * SWEEP);
      end
    end
  end

  initial begin
    logic [11:0] set;
    int r, a, b;
    model_reset();
    @(negedge clk);
    do_reset();

    run('0, 3);                        // idle scan
    run(km(5), 5);  run('0, 5);        // key 6
    run(km(0), 2);  run('0, 2);        // short press of 1
    run(km(9), 4);  run('0, 5);        // *
    run(km(10), 4); run('0, 5);        // 0
    run(km(11), 4); run('0, 5);        // #
    run(km(1) | km(4), 5); run('0, 5); // 2+5 together
    run(km(8), 4);  run(km(0), 3);     // 9 then roll onto 1
    run('0, 4);     run(km(0), 4); run('0, 5);
    run(km(3), 2);                     // key 4 into candidate, then reset
    do_reset();
    run(km(3), 2);  run(km(3), 1); run('0, 5);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) set = '0;
      else if (r < 8) set = km($urandom_range(0, 11));
      else begin
        a = $urandom_range(0, 11);
        b = (a + $urandom_range(1, 11)) % 12;
        set = km(a) | km(b);
      end
      run(set, $urandom_range(1, 5));
    end
    run('0, 5);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
